// File: rtl/lp_frame_serializer.sv
// Frame serializer: buffers whole filter frames with their error code in a small FIFO
// and streams them out as WORD_W-bit words on a valid/ready interface.
module lp_frame_serializer #(
  parameter int WORD_W     = 16,
  parameter int NUM_WORDS  = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD_W*NUM_WORDS-1:0]   in_data,
  input  logic                          in_valid,
  input  logic [1:0]                    in_err,
  output logic                          in_ready,
  output logic [WORD_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [1:0]                    out_err,
  output logic                          overflow,
  output logic [15:0]                   frame_cnt
);

  localparam int FRAME_W = WORD_W * NUM_WORDS;
  localparam int ENTRY_W = FRAME_W + 2;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [FRAME_W-1:0]  r_shift;
  logic [1:0]          r_err;
  logic [IDX_W-1:0]    r_idx;
  logic                r_overflow;
  logic [15:0]         r_frame_cnt;

  logic                w_in_ready;
  logic                w_push;
  logic                w_pop;
  logic                w_out_valid;
  logic                w_is_last;
  logic                w_hs;
  logic                w_frame_done;
  logic [ENTRY_W-1:0]  w_head;

  // in_ready depends only on the registered count, so a same-cycle pop never raises it.
  assign w_in_ready   = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_push       = in_valid && w_in_ready;
  assign w_is_last    = (r_idx == IDX_W'(NUM_WORDS - 1));
  assign w_hs         = w_out_valid && out_ready;
  assign w_frame_done = w_hs && w_is_last;
  assign w_head       = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_err, in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Popping is gated on the registered count, so a frame pushed into an empty
  // FIFO is only taken on the following edge.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
        w_out_valid = 1'b1;
        if (w_frame_done) begin
          if (r_count != '0) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_err   <= '0;
      r_idx   <= '0;
    end else if (w_pop) begin
      r_shift <= w_head[FRAME_W-1:0];
      r_err   <= w_head[ENTRY_W-1:FRAME_W];
      r_idx   <= '0;
    end else if (w_frame_done) begin
      // Clear so the idle outputs read back as zero.
      r_shift <= '0;
      r_err   <= '0;
      r_idx   <= '0;
    end else if (w_hs) begin
      r_shift <= r_shift >> WORD_W;
      r_idx   <= r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (in_valid && !w_in_ready) begin
        r_overflow <= 1'b1;
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_shift[WORD_W-1:0];
  assign out_err   = r_err;
  assign out_last  = w_out_valid && w_is_last;
  assign overflow  = r_overflow;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_lp_frame_serializer.sv
// Bench for lp_frame_serializer: a scoreboard queue of expected words fed by the
// frame driver and drained by a handshake monitor, plus table-driven backpressure runs.
module tb_lp_frame_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] in_data;
  logic        in_valid;
  logic [1:0]  in_err;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [1:0]  out_err;
  logic        overflow;
  logic [15:0] frame_cnt;

  lp_frame_serializer #(.WORD_W(16), .NUM_WORDS(6), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_err(in_err), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_err(out_err),
    .overflow(overflow), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [1:0]  err;
  } word_t;

  typedef struct {
    logic [95:0] data;
    logic [1:0]  err;
    logic [7:0]  rdy;
    logic [15:0] exp_cnt;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    n_hs   = 0;
  word_t exp_q[$];
  word_t held;
  logic  held_v = 1'b0;
  vec_t  vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] mkframe(input logic [15:0] b);
    logic [95:0] f;
    for (int i = 0; i < 6; i++) f[i*16 +: 16] = b + 16'(i);
    return f;
  endfunction

  // Handshake monitor: the word seen here transfers on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_word", 32'({out_data, out_last, out_err}), 32'(held));
      end
      if (out_valid && out_ready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%h required=none", out_data);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          check("word", 32'({out_data, out_last, out_err}), 32'(e));
          $display("WORD %0d data=%h last=%b err=%b", n_hs, out_data, out_last, out_err);
        end
      end
      held_v = out_valid && !out_ready;
      held   = {out_data, out_last, out_err};
    end
  end

  // Present a frame for one cycle; expected words are queued only if it will be accepted.
  task automatic push_frame(input logic [95:0] d, input logic [1:0] e);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    in_err   = e;
    if (in_ready) begin
      for (int i = 0; i < 6; i++) exp_q.push_back({d[i*16 +: 16], (i == 5), e});
    end
  endtask

  task automatic drain(input string name);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    logic hit;

    vecs[0] = '{96'h0006_0005_0004_0003_0002_0001, 2'b01, 8'hFF,        16'd2};
    vecs[1] = '{96'h0006_0005_0004_0003_0002_0001, 2'b01, 8'b1001_1001, 16'd3};
    vecs[2] = '{96'hBEEF_1234_CAFE_0F0F_A5A5_5A5A, 2'b11, 8'b0101_0101, 16'd4};
    vecs[3] = '{96'h8000_7FFF_0000_FFFF_1111_2222, 2'b00, 8'b1110_0000, 16'd5};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_err = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    rst = 1'b0;

    // Latency: pushed at edge N, first word visible after edge N+1.
    push_frame(96'h0006_0005_0004_0003_0002_0001, 2'b01);
    @(posedge clk); #1; in_valid = 1'b0;
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_word0", 32'(out_data), 32'h0001);
    drain("lat_drain");
    check("lat_frame_cnt", 32'(frame_cnt), 32'd1);

    for (int v = 0; v < 4; v++) begin
      base = n_hs;
      push_frame(vecs[v].data, vecs[v].err);
      for (int c = 0; c < 200; c++) begin
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = vecs[v].rdy[c % 8];
        if (exp_q.size() == 0 && !out_valid) break;
      end
      check("vec_drain", 32'(exp_q.size()), 32'd0);
      check("vec_handshakes", 32'(n_hs - base), 32'd6);
      check("vec_frame_cnt", 32'(frame_cnt), 32'(vecs[v].exp_cnt));
      out_ready = 1'b1;
    end

    // Back-to-back: twelve contiguous valid words, no bubble.
    push_frame(mkframe(16'h0A00), 2'b10);
    push_frame(mkframe(16'h0B00), 2'b01);
    @(posedge clk); #1; in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("b2b_contiguous", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    check("b2b_idle_after", 32'(out_valid), 32'd0);
    check("b2b_frame_cnt", 32'(frame_cnt), 32'd7);

    // Overflow: one frame in the shift register, two in the FIFO, the fourth dropped.
    @(posedge clk); #1; out_ready = 1'b0;
    push_frame(mkframe(16'h1000), 2'b00);
    push_frame(mkframe(16'h2000), 2'b01);
    push_frame(mkframe(16'h3000), 2'b10);
    push_frame(mkframe(16'h4000), 2'b11);
    check("ovf_in_ready_full", 32'(in_ready), 32'd0);
    check("ovf_not_yet", 32'(overflow), 32'd0);
    @(posedge clk); #1; in_valid = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    base = n_hs;
    drain("ovf_drain");
    check("ovf_handshakes", 32'(n_hs - base), 32'd18);
    check("ovf_frame_cnt", 32'(frame_cnt), 32'd10);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset after three words of a frame, with another queued.
    base = n_hs;
    push_frame(mkframe(16'h5000), 2'b01);
    push_frame(mkframe(16'h6000), 2'b10);
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #2;
      in_valid = 1'b0;
      if (n_hs - base >= 3) begin hit = 1'b1; break; end
    end
    check("mid_reached", 32'(hit), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid_in_ready",  32'(in_ready),  32'd1);
    check("mid_overflow",  32'(overflow),  32'd0);
    exp_q.delete();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #2;
      check("mid_quiet", 32'(out_valid), 32'd0);
    end

    // Counter wrap.
    force dut.r_frame_cnt = 16'hFFFF;
    #1 release dut.r_frame_cnt;
    check("wrap_preload", 32'(frame_cnt), 32'hFFFF);
    push_frame(mkframe(16'h7000), 2'b00);
    drain("wrap_drain");
    check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
